// File: rtl/muldiv_unit_if.sv
// Start/busy/done handshake bundle for the iterative RV32M multiply/divide unit.
// The pipeline controller is the master; the unit is the slave.
interface muldiv_if;
  logic        start;
  logic [31:0] d1;
  logic [31:0] d2;
  logic [2:0]  control;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;

  modport master (
    output start, d1, d2, control,
    input  busy, done, result, zero
  );

  modport slave (
    input  start, d1, d2, control,
    output busy, done, result, zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring
// shift-subtract steps on magnitudes, then one sign-fix cycle.
module muldiv_unit (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t      state;
  state_t      nxt;
  logic        accept;
  logic [5:0]  cnt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] dv;
  logic [2:0]  op;
  logic        neg_m;
  logic        neg_r;
  logic [31:0] res_q;
  logic        zero_q;

  logic        a_sgn;
  logic        b_sgn;
  logic        sa;
  logic        sb;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        neg_m_in;

  assign a_sgn = bus.control inside {3'b001, 3'b010, 3'b100, 3'b110};
  assign b_sgn = bus.control inside {3'b001, 3'b100, 3'b110};
  assign sa    = a_sgn & bus.d1[31];
  assign sb    = b_sgn & bus.d2[31];
  assign mag_a = sa ? -bus.d1 : bus.d1;
  assign mag_b = sb ? -bus.d2 : bus.d2;
  // x/0 must yield all ones for DIV too, so the quotient is never negated
  assign neg_m_in = (sa ^ sb)
                  & ~(bus.control[2] & (bus.d2 == 32'd0));

  logic [32:0] sum;
  logic [32:0] t;
  logic        ge;
  logic [31:0] diff;

  assign sum  = {1'b0, hi} + (lo[0] ? {1'b0, dv} : 33'd0);
  assign t    = {hi, lo[31]};
  assign ge   = t >= {1'b0, dv};
  assign diff = t[31:0] - dv;

  logic [63:0] prod;
  logic [63:0] prod_n;
  logic [31:0] quo_n;
  logic [31:0] rem_n;
  logic [31:0] fix_res;

  assign prod   = {hi, lo};
  assign prod_n = neg_m ? -prod : prod;
  assign quo_n  = neg_m ? -lo : lo;
  assign rem_n  = neg_r ? -hi : hi;

  always_comb begin
    fix_res = prod_n[63:32];
    unique case (1'b1)
      op == 3'b000:    fix_res = prod_n[31:0];
      op[2] && !op[1]: fix_res = quo_n;
      op[2] && op[1]:  fix_res = rem_n;
      default:         fix_res = prod_n[63:32];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt    = state;
    accept = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          accept = 1'b1;
          nxt    = RUN;
        end else begin
          nxt = IDLE;
        end
      end
      RUN:     if (cnt == 6'd31) nxt = FIX;
      FIX:     nxt = DONE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      dv     <= '0;
      op     <= '0;
      neg_m  <= 1'b0;
      neg_r  <= 1'b0;
      res_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      if (accept) begin
        cnt   <= '0;
        hi    <= '0;
        lo    <= mag_a;
        dv    <= mag_b;
        op    <= bus.control;
        neg_m <= neg_m_in;
        neg_r <= sa;
      end else if (state == RUN) begin
        cnt <= cnt + 6'd1;
        if (!op[2]) begin
          hi <= sum[32:1];
          lo <= {sum[0], lo[31:1]};
        end else begin
          hi <= ge ? diff : t[31:0];
          lo <= {lo[30:0], ge};
        end
      end
      if (state == FIX) begin
        res_q  <= fix_res;
        zero_q <= (fix_res == 32'd0);
      end
    end
  end

  assign bus.busy   = (state == RUN) || (state == FIX);
  assign bus.done   = (state == DONE);
  assign bus.result = res_q;
  assign bus.zero   = zero_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model plus a
// cycle-level handshake model, compared every falling edge.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  muldiv_if bus();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s got=%08h exp=%08h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] model_fn(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [2:0]  op);
    longint      sa;
    longint      sb;
    longint      ub;
    longint      p;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    u  = {32'd0, a} * {32'd0, b};
    model_fn = 32'd0;
    case (op)
      3'd0: begin p = sa * sb; model_fn = p[31:0];  end
      3'd1: begin p = sa * sb; model_fn = p[63:32]; end
      3'd2: begin p = sa * ub; model_fn = p[63:32]; end
      3'd3: model_fn = u[63:32];
      3'd4: begin
        if (b == 0) model_fn = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF)
          model_fn = 32'h80000000;
        else begin p = sa / sb; model_fn = p[31:0]; end
      end
      3'd5: model_fn = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) model_fn = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF)
          model_fn = 32'd0;
        else begin p = sa % sb; model_fn = p[31:0]; end
      end
      default: model_fn = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Handshake model: 33 edges after acceptance the result lands
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_res  = 32'd0;
  logic [31:0] m_pend = 32'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_res  <= 32'd0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_res  <= m_pend;
        m_done <= 1'b1;
      end
    end else begin
      m_done <= 1'b0;
      if (bus.start) begin
        m_pend <= model_fn(bus.d1, bus.d2, bus.control);
        m_left <= 33;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_busy", {31'd0, bus.busy}, {31'd0, m_left != 0});
      chk("cyc_done", {31'd0, bus.done}, {31'd0, m_done});
      chk("cyc_result", bus.result, m_res);
      chk("cyc_zero", {31'd0, bus.zero}, {31'd0, m_res == 32'd0});
      chk("cyc_excl", {31'd0, bus.busy & bus.done}, 32'd0);
    end
  end

  task automatic scramble();
    bus.d1      = $urandom;
    bus.d2      = $urandom;
    bus.control = 3'($urandom);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [31:0] exp,
                        input string nm);
    int k;
    bit seen;
    @(negedge clk);
    bus.d1 = a; bus.d2 = b; bus.control = op; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    scramble();
    k = 0; seen = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (bus.done) seen = 1;
    end
    chk({nm, "_lat"}, 32'(k), 32'd33);
    chk(nm, bus.result, exp);
    chk({nm, "_zero"}, {31'd0, bus.zero}, {31'd0, exp == 32'd0});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    bit  seen;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    bus.start = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_op(32'h10101010, 32'h01010101, 3'd0, 32'h40302010, "mul");
    run_op(32'h01010101, 32'h01010101, 3'd0, 32'h04030201, "mul2");

    // asynchronous reset in the middle of a cycle, mid-operation
    @(negedge clk);
    bus.d1 = 32'hFFFFFFFF; bus.d2 = 32'hFFFFFFFF;
    bus.control = 3'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_done", {31'd0, bus.done}, 32'd0);
    chk("arst_result", bus.result, 32'd0);
    chk("arst_zero", {31'd0, bus.zero}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd1, 32'h00000000, "mulh");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd3, 32'hFFFFFFFE, "mulhu");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd2, 32'hFFFFFFFF, "mulhsu");
    run_op(32'hFFFFFFF9, 32'd2, 3'd4, 32'hFFFFFFFD, "div");
    run_op(32'hFFFFFFF9, 32'd2, 3'd6, 32'hFFFFFFFF, "rem");
    run_op(32'h10101010, 32'h10101010, 3'd5, 32'd1, "divu");
    run_op(32'h12345678, 32'd0, 3'd5, 32'hFFFFFFFF, "divu_z");
    run_op(32'hFFFFFFF9, 32'd0, 3'd4, 32'hFFFFFFFF, "div_z");
    run_op(32'd5, 32'd0, 3'd6, 32'd5, "rem_z");
    run_op(32'h80000000, 32'hFFFFFFFF, 3'd4, 32'h80000000, "div_ovf");
    run_op(32'h80000000, 32'hFFFFFFFF, 3'd6, 32'd0, "rem_ovf");

    // start pulses while running must not disturb the op
    @(negedge clk);
    bus.d1 = 32'd1000; bus.d2 = 32'd7; bus.control = 3'd5;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0; seen = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (bus.done) seen = 1;
      bus.start = !seen && (k == 5 || k == 20);
      scramble();
    end
    bus.start = 1'b0;
    chk("ign_lat", 32'(k), 32'd33);
    chk("ign_result", bus.result, 32'd142);

    // start held high through DONE: back-to-back acceptance
    @(negedge clk);
    bus.d1 = 32'd100; bus.d2 = 32'd7; bus.control = 3'd5;
    bus.start = 1'b1;
    k = 0; seen = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (bus.done) seen = 1;
    end
    chk("b2b_lat1", 32'(k), 32'd34);
    chk("b2b_res1", bus.result, 32'd14);
    bus.control = 3'd7;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_nodone", {31'd0, bus.done}, 32'd0);
    k = 1; seen = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (bus.done) seen = 1;
    end
    chk("b2b_gap", 32'(k), 32'd34);
    chk("b2b_res2", bus.result, 32'd2);

    // reset ten cycles into a divide
    @(negedge clk);
    bus.d1 = 32'd999; bus.d2 = 32'd3; bus.control = 3'd4;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    chk("rrun_nodone", {31'd0, seen}, 32'd0);
    chk("rrun_result", bus.result, 32'd0);
    run_op(32'd3, 32'd4, 3'd0, 32'd12, "mul_after");

    for (int i = 0; i < 150; i++) begin
      a  = $urandom;
      b  = $urandom;
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin
          a = $urandom_range(0, 40) - 32'd20;
          b = $urandom_range(0, 10) - 32'd5;
        end
        default: ;
      endcase
      run_op(a, b, op, model_fn(a, b, op), "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
